// File: rtl/adc_snapshot_capture_pkg.sv
// Shared types and constants for the ADC snapshot capture block.
package adc_snapshot_pkg;

    // Capture controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // Trigger mode encodings (mode 3 behaves as software trigger)
    localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
    localparam logic [1:0] TRIG_SW        = 2'd1;
    localparam logic [1:0] TRIG_THRESH    = 2'd2;

endpackage

// File: rtl/adc_snapshot_capture_if.sv
// ADC sample stream (one beat = NSAMP samples, sample 0 in the MSBs).
// The source never sees backpressure, so there is no ready signal.
interface adc_snapshot_capture_if #(
    parameter int NSAMP      = 8,
    parameter int SAMP_WIDTH = 16
);
    logic [NSAMP*SAMP_WIDTH-1:0] tdata;
    logic                        tvalid;

    modport master (output tdata, output tvalid);
    modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/adc_snapshot_capture_trig.sv
// Threshold trigger detector: flags a beat in which any sample magnitude
// strictly exceeds thresh and reports the lowest such sample index.
module adc_trig_detect #(
    parameter  int NSAMP      = 8,
    parameter  int SAMP_WIDTH = 16,
    localparam int IDX_WIDTH  = $clog2(NSAMP)
) (
    input  logic [NSAMP*SAMP_WIDTH-1:0] tdata,
    input  logic [SAMP_WIDTH-1:0]       thresh,
    output logic                        hit,
    output logic [IDX_WIDTH-1:0]        idx
);

    // Exact magnitude as an unsigned value of the same width, so the most
    // negative sample maps to 2**(SAMP_WIDTH-1) instead of overflowing.
    function automatic logic [SAMP_WIDTH-1:0] abs_mag(input logic signed [SAMP_WIDTH-1:0] x);
        logic [SAMP_WIDTH-1:0] u;
        u = x;
        return u[SAMP_WIDTH-1] ? (~u + SAMP_WIDTH'(1)) : u;
    endfunction

    logic signed [SAMP_WIDTH-1:0] samp;

    // Scan from the highest index down so the lowest hitting index wins
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        samp = '0;
        for (int i = NSAMP - 1; i >= 0; i--) begin
            samp = tdata[(NSAMP-1-i)*SAMP_WIDTH +: SAMP_WIDTH];
            if (abs_mag(samp) > thresh) begin
                hit = 1'b1;
                idx = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/adc_snapshot_capture.sv
// Triggered snapshot of one ADC stream into the fabric port of a BRAM.
// Arm starts a capture, the selected trigger opens it, and cap_len words
// (trigger beat first, at address 0) are written before done rises.
module adc_snapshot_capture
    import adc_snapshot_pkg::*;
#(
    parameter  int NSAMP      = 8,
    parameter  int SAMP_WIDTH = 16,
    parameter  int ADDR_WIDTH = 10,
    localparam int DATA_WIDTH = NSAMP * SAMP_WIDTH,
    localparam int IDX_WIDTH  = $clog2(NSAMP)
) (
    input  logic                    fpga_clk,
    input  logic                    arst_n,
    adc_snapshot_capture_if.slave   s,
    input  logic                    arm,
    input  logic                    sw_trig,
    input  logic [1:0]              trig_mode,
    input  logic [SAMP_WIDTH-1:0]   thresh,
    input  logic [ADDR_WIDTH:0]     cap_len,
    output logic [DATA_WIDTH-1:0]   bram_din,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic                    bram_we,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_WIDTH-1:0]    trig_idx,
    output logic [ADDR_WIDTH:0]     words_wr
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_W = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

    // Zero or oversize requests mean a full-depth capture
    function automatic logic [ADDR_WIDTH:0] eff_len(input logic [ADDR_WIDTH:0] req);
        return ((req == '0) || (req > DEPTH)) ? DEPTH : req;
    endfunction

    state_t                  state, state_n;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic                    vld_p1;
    logic                    we_p0;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     words_q;
    logic [ADDR_WIDTH:0]     issued;
    logic                    room;
    logic                    final_wr;
    logic                    done_q;
    logic                    sw_seen;
    logic                    trig_cond;
    logic                    trig_fire;
    logic                    hit;
    logic [IDX_WIDTH-1:0]    hit_idx;
    logic [IDX_WIDTH-1:0]    tidx_q;

    adc_trig_detect #(
        .NSAMP      (NSAMP),
        .SAMP_WIDTH (SAMP_WIDTH)
    ) u_trig (
        .tdata  (s.tdata),
        .thresh (thresh),
        .hit    (hit),
        .idx    (hit_idx)
    );

    // Trigger qualification and write-budget bookkeeping
    always_comb begin
        case (trig_mode)
            TRIG_IMMEDIATE: trig_cond = 1'b1;
            TRIG_THRESH:    trig_cond = hit;
            TRIG_SW:        trig_cond = sw_trig | sw_seen;
            default:        trig_cond = sw_trig | sw_seen;
        endcase
        // Writes already committed: completed ones plus the one on the port now
        issued   = words_q + (vld_p1 ? ONE_W : '0);
        room     = issued < len_q;
        final_wr = vld_p1 && ((words_q + ONE_W) == len_q);
    end

    // Next state and the write request for the beat at stage p0
    always_comb begin
        state_n   = state;
        we_p0     = 1'b0;
        trig_fire = 1'b0;
        case (state)
            ARMED: begin
                if (s.tvalid && trig_cond) begin
                    trig_fire = 1'b1;
                    we_p0     = 1'b1;
                    state_n   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (s.tvalid && room) we_p0 = 1'b1;
                if (final_wr)         state_n = IDLE;
            end
            default: ;
        endcase
        // Arm always restarts and drops the beat accepted this cycle
        if (arm) begin
            state_n   = ARMED;
            we_p0     = 1'b0;
            trig_fire = 1'b0;
        end
    end

    // State register
    always_ff @(posedge fpga_clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_n;
    end

    // ---- stage p0 -> p1: data/valid pipe, counters and status ----
    // Pipeline register plus address, length and status counters
    always_ff @(posedge fpga_clk or negedge arst_n) begin
        if (!arst_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            words_q <= '0;
            done_q  <= 1'b0;
            tidx_q  <= '0;
            sw_seen <= 1'b0;
        end else if (arm) begin
            vld_p1  <= 1'b0;
            addr_q  <= '0;
            len_q   <= eff_len(cap_len);
            words_q <= '0;
            done_q  <= 1'b0;
            tidx_q  <= '0;
            sw_seen <= 1'b0;
        end else begin
            vld_p1 <= we_p0;
            if (we_p0) data_p1 <= s.tdata;
            if (vld_p1) begin
                words_q <= words_q + ONE_W;
                // Hold on the last word so a full-depth capture never wraps
                if (!final_wr) addr_q <= addr_q + ONE_A;
            end
            if (final_wr) done_q <= 1'b1;
            if ((state == ARMED) && sw_trig) sw_seen <= 1'b1;
            if (trig_fire) begin
                sw_seen <= 1'b0;
                tidx_q  <= (trig_mode == TRIG_THRESH) ? hit_idx : '0;
            end
        end
    end

    assign bram_din  = data_p1;
    assign bram_we   = vld_p1;
    assign bram_addr = addr_q;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign trig_idx  = tidx_q;
    assign words_wr  = words_q;

endmodule

// File: tb/tb_adc_snapshot_capture.sv
// Bench for adc_snapshot_capture: threshold vector table, directed
// multi-cycle sequences and randomized captures against a beat-list model.
`timescale 1ns/1ps
module tb_adc_snapshot_capture;

    localparam int NS   = 8;
    localparam int SW   = 16;
    localparam int AW   = 10;
    localparam int DW   = NS * SW;
    localparam int MAXN = 1100;

    logic            fpga_clk = 1'b0;
    logic            arst_n   = 1'b0;
    logic            arm      = 1'b0;
    logic            sw_trig  = 1'b0;
    logic [1:0]      trig_mode = 2'd0;
    logic [SW-1:0]   thresh   = '0;
    logic [AW:0]     cap_len  = '0;
    logic [DW-1:0]   bram_din;
    logic [AW-1:0]   bram_addr;
    logic            bram_we;
    logic            busy;
    logic            done;
    logic [2:0]      trig_idx;
    logic [AW:0]     words_wr;

    int total = 0;
    int bad   = 0;

    adc_snapshot_capture_if #(.NSAMP(NS), .SAMP_WIDTH(SW)) bus ();

    adc_snapshot_capture #(.NSAMP(NS), .SAMP_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
        .fpga_clk  (fpga_clk),
        .arst_n    (arst_n),
        .s         (bus),
        .arm       (arm),
        .sw_trig   (sw_trig),
        .trig_mode (trig_mode),
        .thresh    (thresh),
        .cap_len   (cap_len),
        .bram_din  (bram_din),
        .bram_addr (bram_addr),
        .bram_we   (bram_we),
        .busy      (busy),
        .done      (done),
        .trig_idx  (trig_idx),
        .words_wr  (words_wr)
    );

    always #5 fpga_clk = ~fpga_clk;

    // Stimulus per cycle and per-cycle observations of the outputs
    logic          st_vld [MAXN];
    logic [DW-1:0] st_dat [MAXN];
    logic          ob_we    [MAXN+1];
    logic [AW-1:0] ob_addr  [MAXN+1];
    logic [DW-1:0] ob_din   [MAXN+1];
    logic          ob_done  [MAXN+1];
    logic          ob_busy  [MAXN+1];
    logic [AW:0]   ob_words [MAXN+1];
    logic [2:0]    ob_tidx  [MAXN+1];

    typedef struct {
        int            th;
        logic [DW-1:0] beat;
        logic          exp_hit;
        logic [2:0]    exp_idx;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] put(input logic [DW-1:0] b, input int i, input int val);
        logic [DW-1:0] r;
        logic [SW-1:0] v16;
        r   = b;
        v16 = val[SW-1:0];
        r[SW*(NS-1-i) +: SW] = v16;
        return r;
    endfunction

    // Signed sample i of a beat as a plain integer (sample 0 in the MSBs)
    function automatic int samp(input logic [DW-1:0] b, input int i);
        logic [DW-1:0] t;
        logic [SW-1:0] s16;
        t   = b >> (SW * (NS - 1 - i));
        s16 = t[SW-1:0];
        return int'($signed(s16));
    endfunction

    function automatic int first_hit(input logic [DW-1:0] b, input int th);
        int v;
        for (int i = 0; i < NS; i++) begin
            v = samp(b, i);
            if (v < 0) v = -v;
            if (v > th) return i;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] b;
        b = '0;
        for (int j = 0; j < NS; j++) b = put(b, j, int'($urandom_range(0, 3000)) - 1500);
        return b;
    endfunction

    task automatic step();
        @(posedge fpga_clk);
        #1;
    endtask

    // Drive n cycles (arm in cycle 0), then check every observed cycle
    // against the writes implied by the trigger rule and the beat list.
    task automatic run_capture(input int mode, input int th, input int clen,
                               input int n, input int sw_cyc, input string tag);
        int   len, t, nexp, k, hidx;
        int   wr_cyc [MAXN];
        logic exp_we, exp_done;
        for (int i = 0; i < n; i++) begin
            arm        = (i == 0);
            sw_trig    = (i == sw_cyc);
            trig_mode  = 2'(mode);
            thresh     = SW'(th);
            cap_len    = (AW+1)'(clen);
            bus.tvalid = st_vld[i];
            bus.tdata  = st_dat[i];
            step();
            ob_we[i+1]    = bram_we;
            ob_addr[i+1]  = bram_addr;
            ob_din[i+1]   = bram_din;
            ob_done[i+1]  = done;
            ob_busy[i+1]  = busy;
            ob_words[i+1] = words_wr;
            ob_tidx[i+1]  = trig_idx;
        end
        arm = 1'b0; sw_trig = 1'b0; bus.tvalid = 1'b0;

        len = (clen == 0 || clen > (1 << AW)) ? (1 << AW) : clen;
        t = -1;
        for (int i = 1; i < n && t < 0; i++) begin
            if (st_vld[i]) begin
                if (mode == 0) t = i;
                else if (mode == 2) begin
                    if (first_hit(st_dat[i], th) >= 0) t = i;
                end else if (sw_cyc >= 1 && i >= sw_cyc) t = i;
            end
        end
        nexp = 0;
        if (t >= 0) begin
            for (int i = t; i < n && nexp < len; i++) begin
                if (st_vld[i]) begin
                    wr_cyc[nexp] = i + 1;
                    nexp++;
                end
            end
        end
        hidx = (t >= 0 && mode == 2) ? first_hit(st_dat[t], th) : 0;
        k = 0;
        for (int o = 1; o <= n; o++) begin
            exp_we   = (k < nexp) && (wr_cyc[k] == o);
            exp_done = (nexp == len) && (k == len);
            chk({tag, "_we"},    DW'(ob_we[o]),    DW'(exp_we));
            chk({tag, "_words"}, DW'(ob_words[o]), DW'(k));
            chk({tag, "_done"},  DW'(ob_done[o]),  DW'(exp_done));
            chk({tag, "_busy"},  DW'(ob_busy[o]),  DW'(!exp_done));
            chk({tag, "_tidx"},  DW'(ob_tidx[o]),  DW'((t >= 0 && o > t) ? hidx : 0));
            if (exp_we) begin
                chk({tag, "_addr"}, DW'(ob_addr[o]), DW'(k));
                chk({tag, "_din"},  ob_din[o],       st_dat[wr_cyc[k]-1]);
                k++;
            end
        end
    endtask

    initial begin
        int mode, th, cl, sw, nwe;
        bus.tvalid = 1'b0;
        bus.tdata  = '0;

        vecs[0] = '{1000,  put('0, 3, -1001),                   1'b1, 3'd3};
        vecs[1] = '{1000,  put('0, 2, 1000),                    1'b0, 3'd0};
        vecs[2] = '{1000,  put(put('0, 5, 1001), 6, -1000),     1'b1, 3'd5};
        vecs[3] = '{32767, put('0, 0, -32768),                  1'b1, 3'd0};
        vecs[4] = '{32767, put(put('0, 7, 32767), 1, -32767),   1'b0, 3'd0};
        vecs[5] = '{1000,  put(put('0, 1, -1001), 6, 2000),     1'b1, 3'd1};

        // Reset state
        repeat (3) @(posedge fpga_clk);
        #1;
        chk("rst_din",   bram_din,        '0);
        chk("rst_addr",  DW'(bram_addr),  '0);
        chk("rst_we",    DW'(bram_we),    '0);
        chk("rst_busy",  DW'(busy),       '0);
        chk("rst_done",  DW'(done),       '0);
        chk("rst_tidx",  DW'(trig_idx),   '0);
        chk("rst_words", DW'(words_wr),   '0);
        arst_n = 1'b1;
        step();

        // Mode 0, length 4, continuous ramp
        for (int i = 0; i < 12; i++) begin
            st_vld[i] = 1'b1;
            st_dat[i] = '0;
            for (int j = 0; j < NS; j++) st_dat[i] = put(st_dat[i], j, i * NS + j);
        end
        run_capture(0, 0, 4, 12, -1, "m0");
        chk("m0_last_addr", DW'(ob_addr[5]), DW'(3));
        chk("m0_last_din",  ob_din[5],       st_dat[4]);
        chk("m0_done_late", DW'(ob_done[6]), DW'(1));
        chk("m0_words_end", DW'(words_wr),   DW'(4));
        chk("m0_busy_end",  DW'(busy),       DW'(0));

        // Threshold table: two quiet beats, then the test beat
        for (int v = 0; v < 6; v++) begin
            arm = 1'b1; trig_mode = 2'd2; thresh = SW'(vecs[v].th); cap_len = (AW+1)'(1);
            bus.tvalid = 1'b0; bus.tdata = '0;
            step();
            arm = 1'b0; bus.tvalid = 1'b1;
            step();
            step();
            bus.tdata = vecs[v].beat;
            step();
            bus.tvalid = 1'b0; bus.tdata = '0;
            chk("tbl_we", DW'(bram_we), DW'(vecs[v].exp_hit));
            if (vecs[v].exp_hit) begin
                chk("tbl_din",  bram_din,        vecs[v].beat);
                chk("tbl_addr", DW'(bram_addr),  '0);
                chk("tbl_tidx", DW'(trig_idx),   DW'(vecs[v].exp_idx));
            end
            step();
            chk("tbl_done",  DW'(done),     DW'(vecs[v].exp_hit));
            chk("tbl_busy",  DW'(busy),     DW'(!vecs[v].exp_hit));
            chk("tbl_words", DW'(words_wr), DW'(vecs[v].exp_hit));
        end

        // Mode 1, valid toggling, sw_trig on an invalid cycle
        for (int i = 0; i < 12; i++) begin
            st_vld[i] = (i % 2 == 0);
            st_dat[i] = rand_beat();
        end
        run_capture(1, 0, 3, 12, 3, "m1");
        nwe = 0;
        for (int o = 1; o <= 12; o++) nwe += int'(ob_we[o]);
        chk("m1_we_count", DW'(nwe),         DW'(3));
        chk("m1_first",    ob_din[5],        st_dat[4]);
        chk("m1_gap_addr", DW'(ob_addr[6]),  DW'(1));

        // Full depth via cap_len 0 and an oversize cap_len
        for (int i = 0; i < 1030; i++) begin
            st_vld[i] = 1'b1;
            st_dat[i] = rand_beat();
        end
        run_capture(0, 0, 0, 1030, -1, "fd0");
        chk("fd0_last_addr", DW'(ob_addr[1025]), DW'(1023));
        chk("fd0_no_more",   DW'(ob_we[1026]),   DW'(0));
        run_capture(0, 0, 2000, 1030, -1, "fd2k");
        chk("fd2k_last_addr", DW'(ob_addr[1025]), DW'(1023));
        chk("fd2k_words",     DW'(words_wr),      DW'(1024));
        chk("fd2k_done",      DW'(done),          DW'(1));

        // Restart: arm again after 5 words
        for (int i = 0; i < 20; i++) begin
            st_vld[i] = 1'b1;
            st_dat[i] = rand_beat();
        end
        run_capture(0, 0, 10, 7, -1, "rs");
        chk("rs_words5", DW'(words_wr), DW'(5));
        arm = 1'b1; trig_mode = 2'd1; cap_len = (AW+1)'(10);
        bus.tvalid = 1'b1; bus.tdata = rand_beat();
        step();
        arm = 1'b0;
        chk("rs_words0", DW'(words_wr), DW'(0));
        chk("rs_we",     DW'(bram_we),  DW'(0));
        chk("rs_busy",   DW'(busy),     DW'(1));
        chk("rs_done",   DW'(done),     DW'(0));
        for (int i = 0; i < 3; i++) begin
            bus.tdata = rand_beat();
            step();
            chk("rs_armed_we",   DW'(bram_we),  DW'(0));
            chk("rs_armed_busy", DW'(busy),     DW'(1));
        end
        bus.tvalid = 1'b0;

        // Asynchronous reset in the middle of a capture
        run_capture(0, 0, 20, 8, -1, "ar");
        #2 arst_n = 1'b0;
        #1;
        chk("ar_din",   bram_din,       '0);
        chk("ar_addr",  DW'(bram_addr), '0);
        chk("ar_we",    DW'(bram_we),   '0);
        chk("ar_busy",  DW'(busy),      '0);
        chk("ar_done",  DW'(done),      '0);
        chk("ar_tidx",  DW'(trig_idx),  '0);
        chk("ar_words", DW'(words_wr),  '0);
        step();
        #3 arst_n = 1'b1;
        step();
        run_capture(0, 0, 5, 12, -1, "ar_post");
        chk("ar_post_done", DW'(done), DW'(1));

        // Randomized captures over all modes
        for (int r = 0; r < 12; r++) begin
            mode = int'($urandom_range(0, 3));
            th   = int'($urandom_range(900, 1600));
            cl   = int'($urandom_range(1, 12));
            sw   = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 25));
            for (int i = 0; i < 40; i++) begin
                st_vld[i] = ($urandom_range(0, 99) < 70);
                st_dat[i] = rand_beat();
            end
            run_capture(mode, th, cl, 40, sw, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
